// File: rtl/ofdm_cfg_alloc_regs.sv
// CFG-bus configuration responder: standard select, allocation-vector RAM and
// bit-serial playback. Optional register readback is enabled by OFDM_CFG_READBACK_EN.
module ofdm_cfg_alloc_regs #(
  parameter int AW   = 7,
  parameter int LEN0 = 4,
  parameter int LEN1 = 16,
  parameter int LEN2 = 128
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [31:0] CFG_DAT_I,
  input  logic [1:0]  CFG_ADR_I,
  input  logic        CFG_WE_I,
  input  logic        CFG_STB_I,
  output logic        CFG_ACK_O,
  output logic [31:0] CFG_DAT_O,
  output logic        CFG_RDY_O,
  output logic [1:0]  STD_O,
  output logic        AL_BIT_O,
  output logic        AL_VLD_O,
  output logic        AL_LAST_O,
  input  logic        AL_RD_I
);

  localparam int PW = AW + 1;  // holds word counts 0..2^AW
  localparam int RW = AW + 5;  // bit index within the whole vector

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_RUN
  } rd_state_e;

  function automatic logic [PW-1:0] std_len(input logic [1:0] s);
    case (s)
      2'd0:    return PW'(LEN0);
      2'd1:    return PW'(LEN1);
      2'd2:    return PW'(LEN2);
      default: return '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------
  logic          ack_q;
  logic [1:0]    std_q, std_n;
  logic [PW-1:0] len_q, len_n;
  logic [PW-1:0] wptr_q, wptr_n;
  logic          rdy_q;

  logic wr_std;
  logic wr_word;
  logic word_ok;

  assign wr_std  = CFG_STB_I && CFG_WE_I && (CFG_ADR_I == 2'd0);
  assign wr_word = CFG_STB_I && CFG_WE_I && (CFG_ADR_I == 2'd1);
  assign word_ok = wr_word && (wptr_q < len_q);

  // NOTE: every variable driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    std_n  = std_q;
    len_n  = len_q;
    wptr_n = wptr_q;
    if (wr_std) begin
      std_n  = CFG_DAT_I[1:0];
      len_n  = std_len(CFG_DAT_I[1:0]);
      wptr_n = '0;
    end else if (word_ok) begin
      wptr_n = wptr_q + PW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ack_q  <= 1'b0;
      std_q  <= 2'd0;
      len_q  <= PW'(LEN0);
      wptr_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      ack_q  <= CFG_STB_I;
      std_q  <= std_n;
      len_q  <= len_n;
      wptr_q <= wptr_n;
      rdy_q  <= (wptr_n == len_n);
    end
  end

  assign CFG_ACK_O = ack_q;
  assign CFG_RDY_O = rdy_q;
  assign STD_O     = std_q;

  // ---------------------------------------------------------------------------
  // Allocation RAM: one write port from the bus, one registered read port
  // ---------------------------------------------------------------------------
  logic [31:0]   mem [2**AW];
  logic [AW-1:0] raddr;
  logic [31:0]   rd_q;

  // NOTE: the RAM has no reset; stale words stay unreachable because wptr/len
  // and the reader restart on reset.
  always_ff @(posedge CLK_I) begin
    if (word_ok) begin
      mem[wptr_q[AW-1:0]] <= CFG_DAT_I;
    end
    rd_q <= mem[raddr];
  end

  // ---------------------------------------------------------------------------
  // Playback reader
  // ---------------------------------------------------------------------------
  rd_state_e      state_q, state_n;
  logic [RW-1:0]  rptr_q;
  logic [31:0]    cur_word_q;
  logic [AW-1:0]  widx;
  logic [PW-1:0]  widx_inc;
  logic [AW-1:0]  next_widx;
  logic [RW:0]    last_idx;
  logic           run;
  logic           pop;
  logic           at_last;

  assign run       = (state_q == RD_RUN);
  assign widx      = rptr_q[RW-1:5];
  assign widx_inc  = {1'b0, widx} + PW'(1);
  assign next_widx = (widx_inc == len_q) ? '0 : widx_inc[AW-1:0];
  assign last_idx  = {len_q, 5'b0} - (RW + 1)'(1);
  assign at_last   = ({1'b0, rptr_q} == last_idx);
  // A same-cycle STD write restarts the reader, so the pop is discarded.
  assign pop       = run && AL_RD_I && !wr_std;
  // Word 0 is read while idle/fetching; in RUN the following word is prefetched.
  assign raddr     = run ? next_widx : '0;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= RD_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      RD_IDLE:  if (rdy_q && (len_q != '0)) state_n = RD_FETCH;
      RD_FETCH: state_n = RD_RUN;
      RD_RUN:   state_n = RD_RUN;
      default:  state_n = RD_IDLE;
    endcase
    if (wr_std) begin
      state_n = RD_IDLE;
    end
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      rptr_q     <= '0;
      cur_word_q <= '0;
    end else if (wr_std) begin
      rptr_q <= '0;
    end else if (state_q == RD_FETCH) begin
      rptr_q     <= '0;
      cur_word_q <= rd_q;
    end else if (pop) begin
      rptr_q <= at_last ? '0 : rptr_q + RW'(1);
      if (rptr_q[4:0] == 5'd31) begin
        cur_word_q <= rd_q;
      end
    end
  end

  assign AL_VLD_O  = run;
  assign AL_BIT_O  = run && cur_word_q[rptr_q[4:0]];
  assign AL_LAST_O = run && at_last;

  // ---------------------------------------------------------------------------
  // Optional readback path (overflow flag only matters when it can be read)
  // ---------------------------------------------------------------------------
`ifdef OFDM_CFG_READBACK_EN
  logic        ovf_q;
  logic [31:0] rd_mux;
  logic [31:0] dat_q;

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      ovf_q <= 1'b0;
    end else if (wr_std) begin
      ovf_q <= 1'b0;
    end else if (wr_word && !word_ok) begin
      ovf_q <= 1'b1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (CFG_ADR_I)
      2'd0: rd_mux[1:0] = std_q;
      2'd2: begin
        rd_mux[0]      = rdy_q;
        rd_mux[1]      = ovf_q;
        rd_mux[3:2]    = std_q;
        rd_mux[8 +: PW] = wptr_q;
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      dat_q <= '0;
    end else begin
      dat_q <= (CFG_STB_I && !CFG_WE_I) ? rd_mux : '0;
    end
  end

  assign CFG_DAT_O = dat_q;
`else
  assign CFG_DAT_O = '0;
`endif

endmodule

// File: tb/tb_ofdm_cfg_alloc_regs.sv
// Self-checking bench for ofdm_cfg_alloc_regs: directed sequence with random data,
// checked against a word-array model of the allocation vector.
module tb_ofdm_cfg_alloc_regs;

  localparam int AW   = 7;
  localparam int LEN0 = 4;
  localparam int LEN1 = 16;
  localparam int LEN2 = 128;
`ifdef OFDM_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic [31:0] CFG_DAT_I;
  logic [1:0]  CFG_ADR_I;
  logic        CFG_WE_I;
  logic        CFG_STB_I;
  logic        CFG_ACK_O;
  logic [31:0] CFG_DAT_O;
  logic        CFG_RDY_O;
  logic [1:0]  STD_O;
  logic        AL_BIT_O;
  logic        AL_VLD_O;
  logic        AL_LAST_O;
  logic        AL_RD_I;

  ofdm_cfg_alloc_regs #(.AW(AW), .LEN0(LEN0), .LEN1(LEN1), .LEN2(LEN2)) dut (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .CFG_DAT_I (CFG_DAT_I),
    .CFG_ADR_I (CFG_ADR_I),
    .CFG_WE_I  (CFG_WE_I),
    .CFG_STB_I (CFG_STB_I),
    .CFG_ACK_O (CFG_ACK_O),
    .CFG_DAT_O (CFG_DAT_O),
    .CFG_RDY_O (CFG_RDY_O),
    .STD_O     (STD_O),
    .AL_BIT_O  (AL_BIT_O),
    .AL_VLD_O  (AL_VLD_O),
    .AL_LAST_O (AL_LAST_O),
    .AL_RD_I   (AL_RD_I)
  );

  always #5 CLK_I = ~CLK_I;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural model: the vector is just an array of words plus a bit index.
  logic [1:0]  m_std;
  int          m_len;
  int          m_wptr;
  bit          m_ovf;
  int          m_idx;
  logic [31:0] m_words [2**AW];

  function automatic int len_of(input logic [1:0] s);
    case (s)
      2'd0:    return LEN0;
      2'd1:    return LEN1;
      2'd2:    return LEN2;
      default: return 0;
    endcase
  endfunction

  task automatic m_reset();
    m_std = 2'd0; m_len = LEN0; m_wptr = 0; m_ovf = 1'b0; m_idx = 0;
  endtask

  task automatic m_apply(input logic [1:0] adr, input logic [31:0] dat);
    if (adr == 2'd0) begin
      m_std = dat[1:0]; m_len = len_of(dat[1:0]); m_wptr = 0; m_ovf = 1'b0; m_idx = 0;
    end else if (adr == 2'd1) begin
      if (m_wptr < m_len) begin
        m_words[m_wptr] = dat;
        m_wptr++;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] adr);
    logic [31:0] v;
    v = 32'h0;
    if (adr == 2'd0) v = {30'h0, m_std};
    if (adr == 2'd2) v = (32'(m_wptr) << 8) | (32'(m_std) << 2) | (32'(m_ovf) << 1) |
                         32'(m_wptr == m_len);
    return RB ? v : 32'h0;
  endfunction

  function automatic logic m_bit(input int i);
    logic [31:0] w;
    w = m_words[i / 32];
    return w[i % 32];
  endfunction

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},  32'(CFG_ACK_O), 32'd0);
    check({tag, "_dat"},  CFG_DAT_O,      32'd0);
    check({tag, "_rdy"},  32'(CFG_RDY_O), 32'd0);
    check({tag, "_std"},  32'(STD_O),     32'd0);
    check({tag, "_bit"},  32'(AL_BIT_O),  32'd0);
    check({tag, "_vld"},  32'(AL_VLD_O),  32'd0);
    check({tag, "_last"}, 32'(AL_LAST_O), 32'd0);
  endtask

  task automatic cfg_write(input logic [1:0] adr, input logic [31:0] dat, input string tag);
    CFG_STB_I = 1'b1; CFG_WE_I = 1'b1; CFG_ADR_I = adr; CFG_DAT_I = dat;
    tick();
    m_apply(adr, dat);
    CFG_STB_I = 1'b0; CFG_WE_I = 1'b0;
    check({tag, "_ack"}, 32'(CFG_ACK_O), 32'd1);
    check({tag, "_rdy"}, 32'(CFG_RDY_O), 32'(m_wptr == m_len));
    check({tag, "_std"}, 32'(STD_O),     32'(m_std));
  endtask

  task automatic cfg_read(input logic [1:0] adr, input string tag);
    CFG_STB_I = 1'b1; CFG_WE_I = 1'b0; CFG_ADR_I = adr;
    tick();
    CFG_STB_I = 1'b0;
    check({tag, "_ack"}, 32'(CFG_ACK_O), 32'd1);
    check(tag, CFG_DAT_O, m_read(adr));
  endtask

  // Called right after the write that completes the vector.
  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (AL_VLD_O !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'd2);
  endtask

  task automatic pop_run(input int n, input bit rnd, input string tag);
    bit rd;
    for (int i = 0; i < n; i++) begin
      rd = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      AL_RD_I = rd;
      check({tag, "_vld"},  32'(AL_VLD_O),  32'd1);
      check({tag, "_bit"},  32'(AL_BIT_O),  32'(m_bit(m_idx)));
      check({tag, "_last"}, 32'(AL_LAST_O), 32'(m_idx == m_len * 32 - 1));
      tick();
      if (rd) m_idx = (m_idx + 1) % (m_len * 32);
    end
    AL_RD_I = 1'b0;
  endtask

  initial begin
    int          vld_cnt;
    int          guard;
    logic [31:0] d;

    RST_I = 1'b1; CFG_DAT_I = '0; CFG_ADR_I = '0; CFG_WE_I = 1'b0; CFG_STB_I = 1'b0;
    AL_RD_I = 1'b0;
    m_reset();
    repeat (3) @(posedge CLK_I);
    #1;
    check_idle_outputs("reset");
    RST_I = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // Register map corners: reserved/word reads return 0, reserved write ignored.
    cfg_read(2'd3, "rd_rsvd");
    cfg_read(2'd1, "rd_word");
    cfg_read(2'd0, "rd_std0");
    cfg_read(2'd2, "rd_stat0");
    cfg_write(2'd3, $urandom, "wr_rsvd");
    tick();
    check("ack_idle", 32'(CFG_ACK_O), 32'd0);

    // STD=0 directed vector: only bits 0 and 127 set.
    cfg_write(2'd0, 32'd0, "std0");
    cfg_write(2'd1, 32'h0000_0001, "w0");
    cfg_write(2'd1, 32'h0000_0000, "w1");
    cfg_write(2'd1, 32'h0000_0000, "w2");
    check("pre_rdy", 32'(CFG_RDY_O), 32'd0);
    cfg_write(2'd1, 32'h8000_0000, "w3");
    check("vld_at_rdy", 32'(AL_VLD_O), 32'd0);
    wait_vld("vld_lat0");
    pop_run(129, 1'b0, "play0");

    // STD=3: ready immediately, never plays.
    cfg_write(2'd0, 32'd3, "std3");
    cfg_read(2'd0, "rd_std3");
    vld_cnt = 0;
    repeat (1000) begin
      tick();
      if (AL_VLD_O !== 1'b0) vld_cnt++;
    end
    check("std3_vld_cycles", 32'(vld_cnt), 32'd0);

    // Overflow: 5th word dropped, flag cleared by a new STD write.
    cfg_write(2'd0, 32'd0, "std0b");
    for (int i = 0; i < 4; i++) cfg_write(2'd1, $urandom, "wr_rand4");
    wait_vld("vld_lat1");
    cfg_write(2'd1, $urandom, "wr_ovf");
    cfg_read(2'd2, "stat_ovf");
    pop_run(200, 1'b1, "play_ovf");
    cfg_write(2'd0, 32'd0, "std0c");
    cfg_read(2'd2, "stat_clr");

    // STD=1 mid-playback restart coincident with a pop.
    cfg_write(2'd0, 32'd1, "std1");
    for (int i = 0; i < 16; i++) cfg_write(2'd1, $urandom, "wr_rand16");
    wait_vld("vld_lat2");
    guard = 0;
    while (m_idx != 200 && guard < 3000) begin
      pop_run(1, 1'b1, "play1");
      guard++;
    end
    check("play1_bit200", 32'(AL_BIT_O), 32'(m_bit(m_idx)));
    AL_RD_I = 1'b1;
    cfg_write(2'd0, 32'd0, "std0_pop");
    AL_RD_I = 1'b0;
    check("restart_vld", 32'(AL_VLD_O), 32'd0);
    for (int i = 0; i < 4; i++) cfg_write(2'd1, $urandom, "wr_rand4b");
    wait_vld("vld_lat3");
    pop_run(140, 1'b0, "play_restart");

    // Strobe held three cycles, then the full STD=2 vector with wrap.
    cfg_write(2'd0, 32'd2, "std2");
    CFG_STB_I = 1'b1; CFG_WE_I = 1'b1; CFG_ADR_I = 2'd1;
    for (int k = 0; k < 3; k++) begin
      d = $urandom;
      CFG_DAT_I = d;
      tick();
      m_apply(2'd1, d);
      check("held_ack", 32'(CFG_ACK_O), 32'd1);
    end
    CFG_STB_I = 1'b0; CFG_WE_I = 1'b0;
    tick();
    check("held_ack_end", 32'(CFG_ACK_O), 32'd0);
    check("held_rdy", 32'(CFG_RDY_O), 32'd0);
    cfg_read(2'd2, "stat_held");
    while (m_wptr < m_len) cfg_write(2'd1, $urandom, "wr_rand128");
    wait_vld("vld_lat4");
    pop_run(LEN2 * 32 + 3, 1'b0, "play2");
    pop_run(300, 1'b1, "play2r");

    // Asynchronous reset between clock edges.
    #2;
    RST_I = 1'b1;
    #1;
    check_idle_outputs("async_rst");
    tick();
    RST_I = 1'b0;
    m_reset();
    tick();
    check_idle_outputs("after_rst");
    cfg_read(2'd2, "stat_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
